// File: rtl/machine_timer_pkg.sv
// Shared constants for the machine timer and other MMIO peripherals on the data-memory port:
// register word indices, CTRL bit positions, access-size codes and a lane-merge helper.
package machine_timer_pkg;

  // Word index within the 32-byte window (i_addr[4:2])
  localparam logic [2:0] TMR_MTIME_LO    = 3'd0;
  localparam logic [2:0] TMR_MTIME_HI    = 3'd1;
  localparam logic [2:0] TMR_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] TMR_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] TMR_CTRL        = 3'd4;

  localparam int CTRL_EN = 0;

  // Access size carried in f3[1:0]; same encoding as the load/store unit
  typedef enum logic [1:0] {
    F3_BYTE = 2'b00,
    F3_HALF = 2'b01,
    F3_WORD = 2'b10,
    F3_NONE = 2'b11
  } f3_size_e;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int l = 0; l < 4; l++) begin
      if (mask[l]) res[8*l +: 8] = new_val[8*l +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/machine_timer_if.sv
// Data-memory side bus seen by an MMIO peripheral: address/store/strobes in, read word and select out.
interface machine_timer_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wd;
  logic [2:0]      f3;
  logic            wen;
  logic            rd_en;
  logic [XLEN-1:0] rd;
  logic            sel;

  modport master (output addr, output wd, output f3, output wen, output rd_en,
                  input rd, input sel);
  modport slave  (input addr, input wd, input f3, input wen, input rd_en,
                  output rd, output sel);
endinterface

// File: rtl/machine_timer_mmio_wr_mask.sv
// Store lane mask from access size and address low bits; misaligned or f3=11 stores yield no lanes.
module mmio_wr_mask
  import machine_timer_pkg::*;
(
  input  logic [2:0] f3,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask
);

  // Sign-extension bit of f3 has no bearing on which lanes a store touches
  logic unused_f3_hi;
  assign unused_f3_hi = f3[2];

  always_comb begin
    mask = 4'b0000;
    case (f3_size_e'(f3[1:0]))
      F3_BYTE: mask = 4'b0001 << addr_lo;
      F3_HALF: if (!addr_lo[0]) mask = 4'b0011 << addr_lo;
      F3_WORD: if (addr_lo == 2'b00) mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
  end

endmodule

// File: rtl/machine_timer.sv
// RISC-V mtime/mtimecmp on the data-memory port; combinational reads, writes commit at the edge,
// registered o_tip one cycle after mtime >= mtimecmp.
module machine_timer
  import machine_timer_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h0200_0000,
  parameter int              PRESCALE  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  machine_timer_if.slave   bus,
  output logic             o_tip
);

  localparam int            CW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

  logic [31:0]   mtime_lo;
  logic [31:0]   mtime_hi;
  logic [31:0]   cmp_lo;
  logic [31:0]   cmp_hi;
  logic          en;
  logic [CW-1:0] cnt;
  logic [63:0]   mtime_inc;
  logic [3:0]    lane_mask;
  logic [31:0]   wd32;
  logic [2:0]    off;
  logic          sel;
  logic          wr;
  logic          tick;
  logic [31:0]   rd_word;

  mmio_wr_mask u_wr_mask (
    .f3      (bus.f3),
    .addr_lo (bus.addr[1:0]),
    .mask    (lane_mask)
  );

  assign sel       = (bus.addr[XLEN-1:5] == BASE_ADDR[XLEN-1:5]);
  assign off       = bus.addr[4:2];
  assign wd32      = bus.wd[31:0];
  // A store that enables no lane is not a write at all, so it must not suppress the tick
  assign wr        = sel && bus.wen && (lane_mask != 4'b0000);
  assign tick      = en && (cnt == CNT_MAX);
  assign mtime_inc = {mtime_hi, mtime_lo} + 64'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtime_lo <= '0;
      mtime_hi <= '0;
      cmp_lo   <= '1;
      cmp_hi   <= '1;
      en       <= 1'b1;
      cnt      <= '0;
      o_tip    <= 1'b0;
    end else begin
      o_tip <= ({mtime_hi, mtime_lo} >= {cmp_hi, cmp_lo});

      if (en) cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);

      // Software write to either mtime half wins over the increment; the other half holds
      if (wr && off == TMR_MTIME_LO) begin
        mtime_lo <= lane_merge(mtime_lo, wd32, lane_mask);
      end else if (wr && off == TMR_MTIME_HI) begin
        mtime_hi <= lane_merge(mtime_hi, wd32, lane_mask);
      end else if (tick) begin
        {mtime_hi, mtime_lo} <= mtime_inc;
      end

      if (wr && off == TMR_MTIMECMP_LO) cmp_lo <= lane_merge(cmp_lo, wd32, lane_mask);
      if (wr && off == TMR_MTIMECMP_HI) cmp_hi <= lane_merge(cmp_hi, wd32, lane_mask);
      if (wr && off == TMR_CTRL && lane_mask[0]) en <= wd32[CTRL_EN];
    end
  end

  always_comb begin
    rd_word = '0;
    if (sel && bus.rd_en) begin
      case (off)
        TMR_MTIME_LO:    rd_word = mtime_lo;
        TMR_MTIME_HI:    rd_word = mtime_hi;
        TMR_MTIMECMP_LO: rd_word = cmp_lo;
        TMR_MTIMECMP_HI: rd_word = cmp_hi;
        TMR_CTRL:        rd_word = {31'd0, en};
        default:         rd_word = '0;
      endcase
    end
  end

  assign bus.sel = sel;
  assign bus.rd  = XLEN'(rd_word);

endmodule

// File: tb/tb_machine_timer.sv
// Drives one stimulus stream into a PRESCALE=1 and a PRESCALE=4 timer and checks both against
// a per-cycle arithmetic model of the register map.
module tb_machine_timer;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [2:0]  f3;
  logic        wen;
  logic        rd_en;
  logic        tip1;
  logic        tip4;

  always #5 clk = ~clk;

  machine_timer_if #(.XLEN(32)) bus1 ();
  machine_timer_if #(.XLEN(32)) bus4 ();

  assign bus1.addr  = addr;
  assign bus1.wd    = wd;
  assign bus1.f3    = f3;
  assign bus1.wen   = wen;
  assign bus1.rd_en = rd_en;
  assign bus4.addr  = addr;
  assign bus4.wd    = wd;
  assign bus4.f3    = f3;
  assign bus4.wen   = wen;
  assign bus4.rd_en = rd_en;

  machine_timer #(.XLEN(32), .BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
    .i_clk (clk), .i_rst (rst), .bus (bus1), .o_tip (tip1)
  );
  machine_timer #(.XLEN(32), .BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
    .i_clk (clk), .i_rst (rst), .bus (bus4), .o_tip (tip4)
  );

  // Reference state, index 0 = PRESCALE 1, index 1 = PRESCALE 4
  logic [63:0] mt    [2];
  logic [63:0] cmp   [2];
  logic        en_m  [2];
  int          cnt_m [2];
  logic        tip_m [2];
  int          presc [2];
  bit          model_ok = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic in_window(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < ({1'b0, BASE} + 33'd32));
  endfunction

  function automatic logic lane_on(input logic [31:0] a, input logic [2:0] f, input int l);
    int nb;
    int first;
    if (f[1:0] == 2'b11) return 1'b0;
    nb = 1 << f[1:0];
    if ((a % nb) != 0) return 1'b0;
    first = int'(a % 4);
    return (l >= first) && (l < first + nb);
  endfunction

  function automatic logic [31:0] exp_rd(input int k, input logic [31:0] a, input logic re);
    int w;
    if (!in_window(a) || !re) return 32'd0;
    w = int'((a - BASE) / 4);
    case (w)
      0:       return mt[k][31:0];
      1:       return mt[k][63:32];
      2:       return cmp[k][31:0];
      3:       return cmp[k][63:32];
      4:       return {31'd0, en_m[k]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                            input logic we, input logic r);
    for (int k = 0; k < 2; k++) begin
      logic tick;
      logic touched_mtime;
      int   w;
      if (r) begin
        mt[k] = 64'd0; cmp[k] = '1; en_m[k] = 1'b1; cnt_m[k] = 0; tip_m[k] = 1'b0;
      end else begin
        tick          = en_m[k] && (cnt_m[k] == presc[k] - 1);
        tip_m[k]      = (mt[k] >= cmp[k]);
        touched_mtime = 1'b0;
        w             = int'((a - BASE) / 4);
        if (en_m[k]) cnt_m[k] = (cnt_m[k] + 1) % presc[k];
        if (in_window(a) && we) begin
          for (int l = 0; l < 4; l++) begin
            if (lane_on(a, f, l)) begin
              case (w)
                0: begin mt[k][8*l +: 8] = d[8*l +: 8]; touched_mtime = 1'b1; end
                1: begin mt[k][32+8*l +: 8] = d[8*l +: 8]; touched_mtime = 1'b1; end
                2: cmp[k][8*l +: 8] = d[8*l +: 8];
                3: cmp[k][32+8*l +: 8] = d[8*l +: 8];
                4: if (l == 0) en_m[k] = d[0];
                default: ;
              endcase
            end
          end
        end
        if (!touched_mtime && tick) mt[k] = mt[k] + 64'd1;
      end
    end
  endtask

  task automatic drive_sample(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                              input logic we, input logic re, input logic r);
    addr = a; wd = d; f3 = f; wen = we; rd_en = re; rst = r;
    #4;
    if (model_ok) begin
      chk("rd_p1",  bus1.rd,  exp_rd(0, a, re));
      chk("rd_p4",  bus4.rd,  exp_rd(1, a, re));
      chk("sel_p1", bus1.sel, in_window(a));
      chk("sel_p4", bus4.sel, in_window(a));
      chk("tip_p1", tip1,     tip_m[0]);
      chk("tip_p4", tip4,     tip_m[1]);
    end
  endtask

  task automatic finish_cycle(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                              input logic we, input logic r);
    @(posedge clk);
    model_step(a, d, f, we, r);
    if (r) model_ok = 1;
    #1;
  endtask

  task automatic do_cycle(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                          input logic we, input logic re, input logic r);
    drive_sample(a, d, f, we, re, r);
    finish_cycle(a, d, f, we, r);
  endtask

  task automatic cyc_chk(input int k, input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f, input logic we, input logic [31:0] exp);
    drive_sample(a, d, f, we, 1'b1, 1'b0);
    chk(tag, (k == 0) ? bus1.rd : bus4.rd, exp);
    finish_cycle(a, d, f, we, 1'b0);
  endtask

  task automatic rd_chk(input int k, input string tag, input logic [31:0] a, input logic [31:0] exp);
    cyc_chk(k, tag, a, 32'd0, 3'b010, 1'b0, exp);
  endtask

  task automatic tip_chk(input string tag, input logic exp);
    drive_sample(BASE, 32'd0, 3'b010, 1'b0, 1'b1, 1'b0);
    chk(tag, tip1, exp);
    finish_cycle(BASE, 32'd0, 3'b010, 1'b0, 1'b0);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    do_cycle(a, d, 3'b010, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a);
    do_cycle(a, 32'd0, 3'b010, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] m;
    logic [63:0] frozen;
    presc[0] = 1;
    presc[1] = 4;

    // Reset and free-running count
    do_cycle(BASE, 32'd0, 3'b010, 1'b0, 1'b0, 1'b1);
    rd_chk(0, "reset_lo_0", BASE, 32'd0);
    rd_chk(0, "reset_lo_1", BASE, 32'd1);
    rd_chk(0, "reset_lo_2", BASE, 32'd2);
    rd_chk(0, "reset_cmp_hi", BASE + 12, 32'hFFFF_FFFF);
    tip_chk("reset_tip", 1'b0);

    // Carry LO->HI and full 64-bit wrap
    sw(BASE + 4, 32'd0);
    sw(BASE, 32'hFFFF_FFFF);
    rd(BASE);
    rd_chk(0, "carry_lo", BASE, 32'd0);
    rd_chk(0, "carry_hi", BASE + 4, 32'd1);
    sw(BASE + 4, 32'hFFFF_FFFF);
    sw(BASE, 32'hFFFF_FFFF);
    rd(BASE);
    rd_chk(0, "wrap_lo", BASE, 32'd0);
    rd_chk(0, "wrap_hi", BASE + 4, 32'd0);

    // Interrupt: compare set 5 ahead of the mtime visible in the write cycle
    sw(BASE + 12, 32'd0);
    m = mt[0][31:0];
    sw(BASE + 8, m + 32'd5);
    for (int i = 1; i <= 5; i++) tip_chk("tip_early", 1'b0);
    tip_chk("tip_rise", 1'b1);
    sw(BASE + 12, 32'd1);
    tip_chk("tip_hold", 1'b1);
    tip_chk("tip_drop", 1'b0);

    // Sub-word stores
    sw(BASE + 8, 32'd0);
    do_cycle(BASE + 9, 32'h0000_AB00, 3'b000, 1'b1, 1'b0, 1'b0);
    rd_chk(0, "sb_cmp_lo", BASE + 8, 32'h0000_AB00);
    do_cycle(BASE + 14, 32'h1234_0000, 3'b001, 1'b1, 1'b0, 1'b0);
    rd_chk(0, "sh_cmp_hi", BASE + 12, 32'h1234_0001);
    do_cycle(BASE + 8, 32'hFFFF_FFFF, 3'b011, 1'b1, 1'b0, 1'b0);
    rd_chk(0, "f3_11_nowrite", BASE + 8, 32'h0000_AB00);
    do_cycle(BASE + 10, 32'hFFFF_FFFF, 3'b010, 1'b1, 1'b0, 1'b0);
    rd_chk(0, "misaligned_nowrite", BASE + 8, 32'h0000_AB00);

    // Decode boundaries
    cyc_chk(0, "oob_above", BASE + 32, 32'hFFFF_FFFF, 3'b010, 1'b1, 32'd0);
    cyc_chk(0, "oob_below", BASE - 4, 32'hFFFF_FFFF, 3'b010, 1'b1, 32'd0);
    rd_chk(0, "reserved_18", BASE + 24, 32'd0);
    rd_chk(0, "oob_nochange", BASE + 8, 32'h0000_AB00);

    // Freeze and resume
    sw(BASE + 16, 32'd0);
    frozen = mt[0];
    for (int i = 0; i < 10; i++) rd_chk(0, "frozen_lo", BASE, frozen[31:0]);
    rd_chk(0, "ctrl_rd", BASE + 16, 32'd0);
    sw(BASE + 16, 32'd1);
    for (int i = 0; i < 12; i++) rd(BASE);

    // Write to MTIME_LO exactly on a PRESCALE=4 tick
    for (int i = 0; i < 8 && cnt_m[1] != 3; i++) rd(BASE);
    chk("p4_tick_phase", 64'(cnt_m[1]), 64'd3);
    sw(BASE, 32'h5555_0000);
    rd_chk(1, "collide_lo", BASE, 32'h5555_0000);

    // Reset wins over a simultaneous store
    do_cycle(BASE, 32'h0000_1234, 3'b010, 1'b1, 1'b0, 1'b1);
    rd_chk(0, "rst_store_lo", BASE, 32'd0);
    rd_chk(1, "rst_cmp_hi", BASE + 12, 32'hFFFF_FFFF);
    rd_chk(0, "rst_en", BASE + 16, 32'd1);

    // Random traffic around the window
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      int          sel_r;
      sel_r = int'($urandom_range(0, 15));
      if (sel_r == 0)      a = $urandom;
      else if (sel_r == 1) a = BASE + 32 + $urandom_range(0, 31);
      else if (sel_r == 2) a = BASE - 32'($urandom_range(1, 8));
      else                 a = BASE + $urandom_range(0, 31);
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 64);
      do_cycle(a, d, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
